dsp_simd2x_lane_unpack: RTL and testbench

//  Decodes the packed 48-bit P output of the SIMD 2x INT9xUINT8 cascaded multiply-add chain

---
 rtl/dsp_simd2x_lane_unpack.sv | 111 +++++++++++
 tb/tb_dsp_simd2x_lane_unpack.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_simd2x_lane_unpack.sv
// Splits the packed 48-bit SIMD 2x DSP result into two signed lanes, then rounds,
// scales and clamps each lane to uint8. Also keeps saturating per-lane saturation counters.
module dsp_simd2x_lane_unpack #(
   parameter int LANE_SHIFT = 18,
   parameter int FRAC_BITS  = 7,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             dsp_reset,
   input  logic             clken,
   input  logic             din_valid,
   input  logic [47:0]      din,
   input  logic             cnt_clear,
   output logic             dout_valid,
   output logic [7:0]       pix0,
   output logic [7:0]       pix1,
   output logic [3:0]       sat_flags,
   output logic [CNT_W-1:0] ovf_cnt0,
   output logic [CNT_W-1:0] ovf_cnt1,
   output logic [CNT_W-1:0] unf_cnt0,
   output logic [CNT_W-1:0] unf_cnt1
);
   localparam int L0W = LANE_SHIFT;
   localparam int L1W = 48 - LANE_SHIFT + 1;
   localparam int LW  = (L1W > L0W) ? L1W : L0W;
   localparam int RW  = LW + 1;
   localparam logic signed [RW-1:0] HALF    = RW'(2 ** (FRAC_BITS - 1));
   localparam logic signed [RW-1:0] PIX_MAX = RW'(255);

   logic [2:0]       valid_reg;
   logic [7:0]       pix_all [2];
   logic [1:0]       sat_all [2];
   logic [1:0]       sat_now [2];
   logic [CNT_W-1:0] cnt_all [4];

   always_ff @(posedge clk) begin
      if (dsp_reset)
         valid_reg <= '0;
      else if (clken)
         valid_reg <= {valid_reg[1:0], din_valid};
   end

   // Both lanes share one sign-extended width from S1 on, so S2/S3 are identical per lane.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [LW-1:0] lane_next;
      logic signed [LW-1:0] lane_reg;
      logic signed [RW-1:0] sum;
      logic signed [RW-1:0] rnd_reg;
      logic                 unf;
      logic                 ovf;
      logic [7:0]           pix_reg;
      logic [1:0]           sat_reg;

      if (gi == 0) begin : g_l0
         assign lane_next = LW'($signed(din[L0W-1:0]));
      end else begin : g_l1
         // Lane 0's sign borrowed one from the upper field when the two were summed.
         assign lane_next = LW'($signed(din[47:LANE_SHIFT]))
                          + LW'($signed({1'b0, din[LANE_SHIFT-1]}));
      end

      assign sum = RW'(lane_reg) + HALF;
      assign unf = rnd_reg[RW-1];
      assign ovf = !unf && (rnd_reg > PIX_MAX);

      always_ff @(posedge clk) begin
         if (dsp_reset) begin
            lane_reg <= '0;
            rnd_reg  <= '0;
            pix_reg  <= '0;
            sat_reg  <= '0;
         end else if (clken) begin
            lane_reg <= lane_next;
            rnd_reg  <= sum >>> FRAC_BITS;
            pix_reg  <= unf ? 8'd0 : (ovf ? 8'd255 : rnd_reg[7:0]);
            sat_reg  <= {ovf, unf};
         end
      end

      assign pix_all[gi] = pix_reg;
      assign sat_all[gi] = sat_reg;
      assign sat_now[gi] = {ovf, unf};
   end

   // Counter gi tracks flag bit gi of sat_flags: unf0, ovf0, unf1, ovf1.
   for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic             hit;

      assign hit = valid_reg[1] && sat_now[gi / 2][gi % 2];

      always_ff @(posedge clk) begin
         if (dsp_reset || cnt_clear)
            cnt_reg <= '0;
         else if (clken && hit && (cnt_reg != '1))
            cnt_reg <= cnt_reg + CNT_W'(1);
      end

      assign cnt_all[gi] = cnt_reg;
   end

   assign dout_valid = valid_reg[2];
   assign pix0       = pix_all[0];
   assign pix1       = pix_all[1];
   assign sat_flags  = {sat_all[1], sat_all[0]};
   assign unf_cnt0   = cnt_all[0];
   assign ovf_cnt0   = cnt_all[1];
   assign unf_cnt1   = cnt_all[2];
   assign ovf_cnt1   = cnt_all[3];

endmodule

// File: tb/tb_dsp_simd2x_lane_unpack.sv
// Scoreboard bench for dsp_simd2x_lane_unpack: the driver queues expected pixels computed
// from the packed word's arithmetic meaning; a monitor pops and checks every output beat.
module tb_dsp_simd2x_lane_unpack;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             dsp_reset = 1'b1;
   logic             clken = 1'b0;
   logic             din_valid = 1'b0;
   logic [47:0]      din = '0;
   logic             cnt_clear = 1'b0;
   logic             dout_valid;
   logic [7:0]       pix0, pix1;
   logic [3:0]       sat_flags;
   logic [CNT_W-1:0] ovf_cnt0, ovf_cnt1, unf_cnt0, unf_cnt1;

   dsp_simd2x_lane_unpack #(.LANE_SHIFT(18), .FRAC_BITS(7), .CNT_W(CNT_W)) dut (
      .clk(clk), .dsp_reset(dsp_reset), .clken(clken), .din_valid(din_valid), .din(din),
      .cnt_clear(cnt_clear), .dout_valid(dout_valid), .pix0(pix0), .pix1(pix1),
      .sat_flags(sat_flags), .ovf_cnt0(ovf_cnt0), .ovf_cnt1(ovf_cnt1),
      .unf_cnt0(unf_cnt0), .unf_cnt1(unf_cnt1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] p0;
      logic [7:0] p1;
      logic [3:0] f;
      longint     tag;
   } exp_t;

   exp_t   sb[$];
   longint ce_edges = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   longint exp_cnt [4] = '{0, 0, 0, 0};
   logic   prev_valid = 1'b0;
   logic [7:0] prev_p0 = '0, prev_p1 = '0;
   logic [3:0] prev_f = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Round half up, then floor-divide by 128, then clamp to 0..255.
   function automatic void lane_model(input longint l, output logic [7:0] p,
                                      output logic unf, output logic ovf);
      longint t, r;
      t = l + 64;
      r = (t >= 0) ? t / 128 : -((-t + 127) / 128);
      unf = (r < 0);
      ovf = (r > 255);
      p = unf ? 8'd0 : (ovf ? 8'd255 : 8'(r));
   endfunction

   // P = l1 * 2^18 + l0 with l0 the signed low 18-bit field.
   function automatic exp_t model(input logic [47:0] d);
      exp_t   e;
      longint p, lo, l0, l1;
      logic   u0, o0, u1, o1;
      p  = d[47] ? longint'(d) - (longint'(1) <<< 48) : longint'(d);
      lo = longint'(d[17:0]);
      l0 = (lo >= 131072) ? lo - 262144 : lo;
      l1 = (p - l0) / 262144;
      lane_model(l0, e.p0, u0, o0);
      lane_model(l1, e.p1, u1, o1);
      e.f = {o1, u1, o0, u0};
      e.tag = 0;
      return e;
   endfunction

   function automatic logic [47:0] mk(input longint l1, input longint l0);
      longint v;
      v = l1 * 262144 + l0;
      return v[47:0];
   endfunction

   task automatic drive(input logic v, input logic [47:0] d, input logic ce,
                        input logic clr, input logic rst);
      exp_t e;
      @(negedge clk);
      din_valid = v;
      din       = d;
      clken     = ce;
      cnt_clear = clr;
      dsp_reset = rst;
      if (rst)
         sb.delete();
      else if (v && ce) begin
         e = model(d);
         e.tag = ce_edges + 1;
         sb.push_back(e);
      end
   endtask

   // Monitor: expected valid, data and counters follow from the queue and edge history.
   always begin
      logic s_rst, s_ce, s_clr, new_beat;
      exp_t e;
      @(posedge clk);
      s_rst = dsp_reset;
      s_ce  = clken;
      s_clr = cnt_clear;
      #1;
      if (s_rst) begin
         chk("reset_valid", longint'(dout_valid), 0);
      end else if (s_ce) begin
         ce_edges++;
         new_beat = (sb.size() > 0) && (sb[0].tag + 2 == ce_edges);
         chk("dout_valid", longint'(dout_valid), longint'(new_beat));
         if (new_beat) begin
            e = sb.pop_front();
            chk("pix0", longint'(pix0), longint'(e.p0));
            chk("pix1", longint'(pix1), longint'(e.p1));
            chk("sat_flags", longint'(sat_flags), longint'(e.f));
            for (int k = 0; k < 4; k++)
               if (e.f[k] && exp_cnt[k] < 65535)
                  exp_cnt[k]++;
         end
      end else begin
         chk("stall_valid", longint'(dout_valid), longint'(prev_valid));
         if (prev_valid) begin
            chk("stall_pix0", longint'(pix0), longint'(prev_p0));
            chk("stall_pix1", longint'(pix1), longint'(prev_p1));
            chk("stall_flags", longint'(sat_flags), longint'(prev_f));
         end
      end
      if (s_rst || s_clr)
         for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
      chk("unf_cnt0", longint'(unf_cnt0), exp_cnt[0]);
      chk("ovf_cnt0", longint'(ovf_cnt0), exp_cnt[1]);
      chk("unf_cnt1", longint'(unf_cnt1), exp_cnt[2]);
      chk("ovf_cnt1", longint'(ovf_cnt1), exp_cnt[3]);
      prev_valid = dout_valid;
      prev_p0    = pix0;
      prev_p1    = pix1;
      prev_f     = sat_flags;
   end

   initial begin
      logic [47:0] d;
      // Reset held for 2 cycles with valid input, then idle.
      drive(1'b1, 48'h123456789abc, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 48'h123456789abc, 1'b1, 1'b0, 1'b1);
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Directed decode cases.
      drive(1'b1, mk(6400, 19200), 1'b1, 1'b0, 1'b0);
      drive(1'b1, mk(25600, 0) - 48'd128, 1'b1, 1'b0, 1'b0);
      drive(1'b1, mk(0, 191), 1'b1, 1'b0, 1'b0);
      drive(1'b1, mk(0, 32704), 1'b1, 1'b0, 1'b0);
      drive(1'b1, mk(-64, 0), 1'b1, 1'b0, 1'b0);
      drive(1'b1, mk(-64, -65), 1'b1, 1'b0, 1'b0);
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Four back-to-back beats, stalled on cycles 2 and 5.
      drive(1'b1, mk(1000, 2000), 1'b1, 1'b0, 1'b0);
      drive(1'b1, mk(3000, 4000), 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(3000, 4000), 1'b1, 1'b0, 1'b0);
      drive(1'b1, mk(5000, 6000), 1'b1, 1'b0, 1'b0);
      drive(1'b1, mk(7000, 8000), 1'b0, 1'b0, 1'b0);
      drive(1'b1, mk(7000, 8000), 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Randomized traffic with stalls, clears and one mid-stream reset.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0)
            d = 48'({$urandom, $urandom});
         else
            d = mk(longint'($urandom_range(0, 70000)) - 35000,
                   longint'($urandom_range(0, 70000)) - 35000);
         drive($urandom_range(0, 9) < 6, d, $urandom_range(0, 3) != 0,
               $urandom_range(0, 49) == 0, i == 700);
      end
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Overflow counter saturation, then a clear on the same edge as an ovf beat.
      repeat (65539) drive(1'b1, mk(0, 32704), 1'b1, 1'b0, 1'b0);
      repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("ovf_cnt0_sat", longint'(ovf_cnt0), 65535);
      drive(1'b1, mk(0, 32704), 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("ovf_cnt0_clear", longint'(ovf_cnt0), 0);
      drive(1'b1, mk(-300, 32704), 1'b1, 1'b0, 1'b0);
      repeat (5) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("ovf_cnt0_after", longint'(ovf_cnt0), 1);
      chk("unf_cnt1_after", longint'(unf_cnt1), 1);
      chk("queue_drained", longint'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
